pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter stage of the Otter core, directly downstream of the branch address generator. It selects the next PC from sequential (PC+4), JAL, branch, JALR, trap-vector and trap-return targets, and registers it. It also holds a redirect while instruction memory is not ready, and diverts misaligned control-transfer targets to the trap vector. Its `PC` output feeds instruction fetch and the branch address generator.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1  core clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `PC_SOURCE`  in  3  next-PC select: 0 = PC+4, 1 = JALR, 2 = BRANCH, 3 = JAL, 4 = MTVEC, 5 = MEPC, 6/7 = treated as 0.
- `PC_WRITE`  in  1  advance request from control, valid for one cycle.
- `JAL`  in  32  JAL target from the branch address generator.
- `BRANCH`  in  32  branch target from the branch address generator.
- `JALR`  in  32  JALR target (rs1 + I-imm) from the branch address generator.
- `MTVEC`  in  32  trap vector base (CSR).
- `MEPC`  in  32  trap return address (CSR).
- `IMEM_READY`  in  1  instruction memory accepts a new fetch address.
- `PC`  out  32  current fetch address (registered).
- `PC_PLUS4`  out  32  PC + 4, combinational from `PC`, modulo 2^32.
- `FETCH_VALID`  out  1  `PC` is a valid fetch request.
- `BUSY`  out  1  redirect pending; control must hold `PC_WRITE` low.
- `MISALIGN`  out  1  one-cycle pulse: misaligned target detected and diverted.
- `MISALIGN_ADDR`  out  32  offending target (mtval source); held until the next misalign event.

## Operation
- Target formation:
  - JALR target = `JALR` with bit 0 cleared.
  - All other targets are used as given.
  - Additions wrap modulo 2^32.
- Misalign rule: the selected target has bits [1:0] != 0 after JALR bit-0 clearing. In that case the effective next PC = `MTVEC`.
  - Sources 0/4/5 are never checked.
- States:
  - BOOT: entered on reset. `FETCH_VALID` = 0. Goes unconditionally to RUN after one clock.
  - RUN:
    - `PC_WRITE` & `IMEM_READY`: PC <= effective next PC; stay in RUN.
    - `PC_WRITE` & !`IMEM_READY`: HOLD_PC <= effective next PC; go to HOLD. PC is unchanged.
    - !`PC_WRITE`: PC holds.
  - HOLD:
    - `BUSY` = 1 and `PC_WRITE` is ignored.
    - When `IMEM_READY` = 1: PC <= HOLD_PC; go to RUN.
- Misalign reporting:
  - `MISALIGN` pulses on the edge where the effective next PC is captured (into PC or HOLD_PC).
  - `MISALIGN_ADDR` is captured on that same edge.
- Reset values: `PC` = `RESET_VECTOR`, HOLD_PC = 0, `FETCH_VALID` = 0, `BUSY` = 0, `MISALIGN` = 0, `MISALIGN_ADDR` = 0, state BOOT.
- Reset asserted in any state (including HOLD) discards the pending redirect immediately.

## Timing
- PC update latency: 1 clock from `PC_WRITE` & `IMEM_READY` sampled high in RUN.
- HOLD exit: PC updates on the first rising edge with `IMEM_READY` = 1. Minimum added latency is 1 cycle per stalled redirect.
- `FETCH_VALID`:
  - 0 during BOOT.
  - 1 in RUN and HOLD; in HOLD it qualifies the old `PC` still being presented.
- `BUSY`: registered; rises the cycle after the stalled `PC_WRITE` and falls on the HOLD exit edge.
- `MISALIGN`: registered; high exactly one cycle, never in BOOT.
- `PC_SOURCE`, targets, `MTVEC` and `MEPC` are sampled only on the edge where `PC_WRITE` is accepted. Later changes do not affect HOLD_PC.
- Simultaneous `PC_WRITE` and HOLD exit: the HOLD exit wins and `PC_WRITE` is dropped. Control is responsible for honouring `BUSY`.
- PC at 32'hFFFF_FFFC with source 0: wraps to 32'h0000_0000 without a flag.

## Test plan
- Reset: `RST_N` = 0 with `RESET_VECTOR` = 0 → `PC` = 0, `FETCH_VALID` = 0. Release `RST_N` → `FETCH_VALID` = 1 after one edge.
- Sequential fetch: source 0, `PC_WRITE` = 1, `IMEM_READY` = 1 for 3 cycles from PC 0 → `PC` = 4, 8, 0xC. Also PC = 0xFFFF_FFFC → 0.
- JALR target clearing: `JALR` = 0x1001, source 1 → `PC` = 0x1000, `MISALIGN` stays 0.
- Misaligned branch: source 2, `BRANCH` = 0x2002, `MTVEC` = 0x100 → `PC` = 0x100; `MISALIGN` = 1 for one cycle; `MISALIGN_ADDR` = 0x2002.
- Stalled redirect: source 3, `JAL` = 0x3000, `IMEM_READY` = 0 for 2 cycles → `PC` held, `BUSY` = 1. Then `IMEM_READY` = 1 → `PC` = 0x3000 on the next edge, `BUSY` = 0.
- Reset during HOLD: assert `RST_N` = 0 while `BUSY` = 1 → `PC` = `RESET_VECTOR` and `BUSY` = 0 without waiting for a clock. After release the pending target is never loaded.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter stage: selects and registers the next fetch address, holds a
// redirect while instruction memory stalls, and diverts misaligned targets to MTVEC.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  PC_SOURCE,
  input  logic        PC_WRITE,
  input  logic [31:0] JAL,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JALR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        IMEM_READY,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FETCH_VALID,
  output logic        BUSY,
  output logic        MISALIGN,
  output logic [31:0] MISALIGN_ADDR,
  output logic [1:0]  DBG_STATE
);

  // Handshake: PC_WRITE is a single-cycle request; it is accepted only in RUN.
  // IMEM_READY low on acceptance parks the target in r_hold_pc and raises BUSY;
  // the first cycle with IMEM_READY high in HOLD loads it and drops any PC_WRITE.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_pc;
  logic        r_misalign;
  logic [31:0] r_misalign_addr;

  logic [31:0] w_target;
  logic        w_checked;
  logic        w_misaligned;
  logic [31:0] w_eff_pc;
  logic        w_load_pc_eff;
  logic        w_load_hold;
  logic        w_load_pc_hold;

  always_comb begin
    w_target  = r_pc + 32'd4;
    w_checked = 1'b0;
    case (PC_SOURCE)
      3'd1: begin w_target = {JALR[31:1], 1'b0}; w_checked = 1'b1; end
      3'd2: begin w_target = BRANCH;             w_checked = 1'b1; end
      3'd3: begin w_target = JAL;                w_checked = 1'b1; end
      3'd4: w_target = MTVEC;
      3'd5: w_target = MEPC;
      default: w_target = r_pc + 32'd4;
    endcase
    w_misaligned = w_checked && (w_target[1:0] != 2'b00);
    w_eff_pc     = w_misaligned ? MTVEC : w_target;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_BOOT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_load_pc_eff  = 1'b0;
    w_load_hold    = 1'b0;
    w_load_pc_hold = 1'b0;
    case (r_state)
      ST_BOOT: w_next_state = ST_RUN;
      ST_RUN: begin
        if (PC_WRITE && IMEM_READY) begin
          w_load_pc_eff = 1'b1;
        end else if (PC_WRITE) begin
          w_load_hold  = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (IMEM_READY) begin
          w_load_pc_hold = 1'b1;
          w_next_state   = ST_RUN;
        end
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc            <= RESET_VECTOR;
      r_hold_pc       <= 32'h0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= 32'h0;
    end else begin
      r_misalign <= 1'b0;
      if (w_load_pc_eff)  r_pc      <= w_eff_pc;
      if (w_load_pc_hold) r_pc      <= r_hold_pc;
      if (w_load_hold)    r_hold_pc <= w_eff_pc;
      // The misalign event is reported when the target is captured, not when it lands in PC.
      if ((w_load_pc_eff || w_load_hold) && w_misaligned) begin
        r_misalign      <= 1'b1;
        r_misalign_addr <= w_target;
      end
    end
  end

  assign PC            = r_pc;
  assign PC_PLUS4      = r_pc + 32'd4;
  assign FETCH_VALID   = (r_state != ST_BOOT);
  assign BUSY          = (r_state == ST_HOLD);
  assign MISALIGN      = r_misalign;
  assign MISALIGN_ADDR = r_misalign_addr;
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: one task per scenario with inline checks
// against hand-computed values, ending in a single summary line.
module tb_pc_next_unit;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  PC_SOURCE;
  logic        PC_WRITE;
  logic [31:0] JAL;
  logic [31:0] BRANCH;
  logic [31:0] JALR;
  logic [31:0] MTVEC;
  logic [31:0] MEPC;
  logic        IMEM_READY;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        FETCH_VALID;
  logic        BUSY;
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;
  logic [1:0]  DBG_STATE;

  int checks   = 0;
  int failures = 0;

  pc_next_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_SOURCE(PC_SOURCE), .PC_WRITE(PC_WRITE),
    .JAL(JAL), .BRANCH(BRANCH), .JALR(JALR), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_READY(IMEM_READY), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .FETCH_VALID(FETCH_VALID), .BUSY(BUSY), .MISALIGN(MISALIGN),
    .MISALIGN_ADDR(MISALIGN_ADDR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; PC_WRITE = 1'b0; PC_SOURCE = 3'd0; IMEM_READY = 1'b1;
    JAL = 32'h0; BRANCH = 32'h0; JALR = 32'h0; MTVEC = 32'h0; MEPC = 32'h0;
    tick(); tick();
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    checks++; if (FETCH_VALID !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid: got %b want 0", FETCH_VALID); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (MISALIGN !== 1'b0 || MISALIGN_ADDR !== 32'h0) begin failures++; $display("FAIL reset_misalign: got %b/%h want 0/0", MISALIGN, MISALIGN_ADDR); end
    checks++; if (PC_PLUS4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4: got %h want %h", PC_PLUS4, 32'h4); end
    RST_N = 1'b1;
    tick();
    checks++; if (FETCH_VALID !== 1'b1) begin failures++; $display("FAIL boot_exit_fetch_valid: got %b want 1", FETCH_VALID); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL boot_exit_pc: got %h want %h", PC, 32'h0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    PC_SOURCE = 3'd0; PC_WRITE = 1'b1; IMEM_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PC !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, exp_pc[i]); end
    end
    PC_WRITE = 1'b0;
    tick();
    checks++; if (PC !== 32'hC) begin failures++; $display("FAIL seq_hold_no_write: got %h want %h", PC, 32'hC); end
  endtask

  task automatic test_wrap();
    PC_SOURCE = 3'd3; JAL = 32'hFFFF_FFFC; PC_WRITE = 1'b1; IMEM_READY = 1'b1;
    tick();
    checks++; if (PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup_pc: got %h want %h", PC, 32'hFFFF_FFFC); end
    checks++; if (PC_PLUS4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4: got %h want %h", PC_PLUS4, 32'h0); end
    PC_SOURCE = 3'd0;
    tick();
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); end
    checks++; if (MISALIGN !== 1'b0) begin failures++; $display("FAIL wrap_no_misalign: got %b want 0", MISALIGN); end
    PC_WRITE = 1'b0;
  endtask

  task automatic test_jalr();
    PC_SOURCE = 3'd1; JALR = 32'h1001; MTVEC = 32'h100; PC_WRITE = 1'b1; IMEM_READY = 1'b1;
    tick();
    PC_WRITE = 1'b0;
    checks++; if (PC !== 32'h1000) begin failures++; $display("FAIL jalr_pc: got %h want %h", PC, 32'h1000); end
    checks++; if (MISALIGN !== 1'b0) begin failures++; $display("FAIL jalr_misalign: got %b want 0", MISALIGN); end
  endtask

  task automatic test_misalign_branch();
    PC_SOURCE = 3'd2; BRANCH = 32'h2002; MTVEC = 32'h100; PC_WRITE = 1'b1; IMEM_READY = 1'b1;
    tick();
    PC_WRITE = 1'b0;
    checks++; if (PC !== 32'h100) begin failures++; $display("FAIL misalign_pc: got %h want %h", PC, 32'h100); end
    checks++; if (MISALIGN !== 1'b1) begin failures++; $display("FAIL misalign_pulse: got %b want 1", MISALIGN); end
    checks++; if (MISALIGN_ADDR !== 32'h2002) begin failures++; $display("FAIL misalign_addr: got %h want %h", MISALIGN_ADDR, 32'h2002); end
    tick();
    checks++; if (MISALIGN !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle: got %b want 0", MISALIGN); end
    checks++; if (MISALIGN_ADDR !== 32'h2002) begin failures++; $display("FAIL misalign_addr_held: got %h want %h", MISALIGN_ADDR, 32'h2002); end
  endtask

  task automatic test_unchecked_sources();
    // MEPC and MTVEC are taken as-is even when not word aligned.
    PC_SOURCE = 3'd5; MEPC = 32'h0000_0203; MTVEC = 32'h100; PC_WRITE = 1'b1; IMEM_READY = 1'b1;
    tick();
    checks++; if (PC !== 32'h203 || MISALIGN !== 1'b0) begin failures++; $display("FAIL mepc_pc: got %h/%b want %h/0", PC, MISALIGN, 32'h203); end
    PC_SOURCE = 3'd4; MTVEC = 32'h0000_0102;
    tick();
    checks++; if (PC !== 32'h102 || MISALIGN !== 1'b0) begin failures++; $display("FAIL mtvec_pc: got %h/%b want %h/0", PC, MISALIGN, 32'h102); end
    PC_SOURCE = 3'd6; MTVEC = 32'h100;
    tick();
    checks++; if (PC !== 32'h106) begin failures++; $display("FAIL src6_pc: got %h want %h", PC, 32'h106); end
    PC_SOURCE = 3'd7;
    tick();
    PC_WRITE = 1'b0;
    checks++; if (PC !== 32'h10A) begin failures++; $display("FAIL src7_pc: got %h want %h", PC, 32'h10A); end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    pc0 = 32'h10A;
    PC_SOURCE = 3'd3; JAL = 32'h3000; PC_WRITE = 1'b1; IMEM_READY = 1'b0;
    tick();
    PC_WRITE = 1'b0; JAL = 32'h7770; // later target changes must not leak into the held redirect
    checks++; if (BUSY !== 1'b1 || PC !== pc0) begin failures++; $display("FAIL stall_c1: got busy=%b pc=%h want busy=1 pc=%h", BUSY, PC, pc0); end
    checks++; if (FETCH_VALID !== 1'b1) begin failures++; $display("FAIL stall_fetch_valid: got %b want 1", FETCH_VALID); end
    tick();
    checks++; if (BUSY !== 1'b1 || PC !== pc0) begin failures++; $display("FAIL stall_c2: got busy=%b pc=%h want busy=1 pc=%h", BUSY, PC, pc0); end
    // simultaneous PC_WRITE on the exit edge is dropped
    IMEM_READY = 1'b1; PC_WRITE = 1'b1; PC_SOURCE = 3'd0;
    tick();
    PC_WRITE = 1'b0;
    checks++; if (PC !== 32'h3000 || BUSY !== 1'b0) begin failures++; $display("FAIL stall_exit: got pc=%h busy=%b want pc=%h busy=0", PC, BUSY, 32'h3000); end
    tick();
    checks++; if (PC !== 32'h3000) begin failures++; $display("FAIL stall_write_dropped: got %h want %h", PC, 32'h3000); end
  endtask

  task automatic test_stall_misalign();
    PC_SOURCE = 3'd3; JAL = 32'h3002; MTVEC = 32'h180; PC_WRITE = 1'b1; IMEM_READY = 1'b0;
    tick();
    PC_WRITE = 1'b0; MTVEC = 32'h200;
    checks++; if (MISALIGN !== 1'b1 || MISALIGN_ADDR !== 32'h3002 || PC !== 32'h3000) begin failures++; $display("FAIL stall_misalign_capture: got %b/%h/%h want 1/%h/%h", MISALIGN, MISALIGN_ADDR, PC, 32'h3002, 32'h3000); end
    IMEM_READY = 1'b1;
    tick();
    checks++; if (PC !== 32'h180 || MISALIGN !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL stall_misalign_exit: got pc=%h mis=%b busy=%b want pc=%h mis=0 busy=0", PC, MISALIGN, BUSY, 32'h180); end
  endtask

  task automatic test_reset_during_hold();
    PC_SOURCE = 3'd3; JAL = 32'h5000; PC_WRITE = 1'b1; IMEM_READY = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rst_hold_setup_busy: got %b want 1", BUSY); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (PC !== 32'h0 || BUSY !== 1'b0 || FETCH_VALID !== 1'b0) begin failures++; $display("FAIL rst_hold_async: got pc=%h busy=%b fv=%b want pc=0 busy=0 fv=0", PC, BUSY, FETCH_VALID); end
    tick();
    RST_N = 1'b1; IMEM_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PC !== 32'h0 || BUSY !== 1'b0) begin failures++; $display("FAIL rst_hold_no_reload[%0d]: got pc=%h busy=%b want pc=0 busy=0", i, PC, BUSY); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_jalr();
    test_misalign_branch();
    test_unchecked_sources();
    test_stall();
    test_stall_misalign();
    test_reset_during_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
